lcd_driver: RTL

- Timing generator and pixel-fetch front end for the 800x480 RGB LCD panel.
- Free-runs horizontal and vertical counters on lcd_pclk and drives the panel sync, data-enable and RGB pins.
- Issues pixel_xpos/pixel_ypos one cycle ahead of display so the registered pixel_data from lcd_display lands aligned with lcd_de.
- Supplies the pixel coordinates that lcd_display consumes and forwards its colour output to the panel pins.

---
 rtl/lcd_timing_pkg.sv | 27 ++
 rtl/lcd_driver.sv | 120 ++++++++++++
 2 files changed

// File: rtl/lcd_timing_pkg.sv
// lcd_timing_pkg
//   Default 800x480 RGB panel timing shared by the LCD front end.
//   Other panel sizes reuse these names and override the driver parameters.
//   Contents: H_*/V_* porch/sync/active defaults, derived totals,
//   counter width and RGB bus width.
package lcd_timing_pkg;

  localparam int CNT_W   = 11;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int RGB_W   = 24;

  localparam int LCD_H_SYNC  = 128;
  localparam int LCD_H_BACK  = 88;
  localparam int LCD_H_DISP  = 800;
  localparam int LCD_H_FRONT = 40;

  localparam int LCD_V_SYNC  = 2;
  localparam int LCD_V_BACK  = 33;
  localparam int LCD_V_DISP  = 480;
  localparam int LCD_V_FRONT = 10;

  localparam int LCD_H_TOTAL = LCD_H_SYNC + LCD_H_BACK + LCD_H_DISP + LCD_H_FRONT;
  localparam int LCD_V_TOTAL = LCD_V_SYNC + LCD_V_BACK + LCD_V_DISP + LCD_V_FRONT;

  localparam logic LCD_SYNC_ACT = 1'b0;

endpackage

// File: rtl/lcd_driver.sv
// lcd_driver
//   Timing generator and pixel-fetch front end for an RGB LCD panel.
//   Free-running h/v counters produce sync, data-enable and the pixel
//   coordinates handed to lcd_display one cycle ahead of lcd_de, so the
//   registered colour that comes back lines up with lcd_de.
//
//   Ports
//     lcd_pclk     in   pixel clock
//     sys_rst_n    in   synchronous active-low reset
//     disp_en      in   display enable, latched once per frame
//     pixel_data   in   colour from lcd_display, 1 cycle after the request
//     pixel_xpos   out  requested column (0 outside the request window)
//     pixel_ypos   out  requested row    (0 outside the request window)
//     data_req     out  pixel_xpos/pixel_ypos valid this cycle
//     lcd_hs       out  horizontal sync
//     lcd_vs       out  vertical sync
//     lcd_de       out  data enable
//     lcd_rgb      out  panel colour bus (0 when lcd_de is low)
//     frame_start  out  one-cycle pulse per frame
module lcd_driver
  import lcd_timing_pkg::*;
#(
  parameter int   H_SYNC   = LCD_H_SYNC,
  parameter int   H_BACK   = LCD_H_BACK,
  parameter int   H_DISP   = LCD_H_DISP,
  parameter int   H_FRONT  = LCD_H_FRONT,
  parameter int   V_SYNC   = LCD_V_SYNC,
  parameter int   V_BACK   = LCD_V_BACK,
  parameter int   V_DISP   = LCD_V_DISP,
  parameter int   V_FRONT  = LCD_V_FRONT,
  parameter logic SYNC_ACT = LCD_SYNC_ACT
) (
  input  logic             lcd_pclk,
  input  logic             sys_rst_n,
  input  logic             disp_en,
  input  logic [RGB_W-1:0] pixel_data,
  output logic [CNT_W-1:0] pixel_xpos,
  output logic [CNT_W-1:0] pixel_ypos,
  output logic             data_req,
  output logic             lcd_hs,
  output logic             lcd_vs,
  output logic             lcd_de,
  output logic [RGB_W-1:0] lcd_rgb,
  output logic             frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

  generate
    if (H_TOTAL > CNT_MAX || V_TOTAL > CNT_MAX) begin : g_total_check
      $error("lcd_driver: H_TOTAL or V_TOTAL does not fit the 11-bit counters");
    end
  endgenerate

  localparam logic [CNT_W-1:0] H_MAX    = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_MAX    = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_SYNC_W = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_W = CNT_W'(V_SYNC);
  // Horizontal window starts one pixel early so the registered colour from
  // lcd_display arrives together with the registered lcd_de.
  localparam logic [CNT_W-1:0] H_REQ_LO = CNT_W'(H_SYNC + H_BACK - 1);
  localparam logic [CNT_W-1:0] H_REQ_HI = CNT_W'(H_SYNC + H_BACK + H_DISP - 1);
  localparam logic [CNT_W-1:0] V_REQ_LO = CNT_W'(V_SYNC + V_BACK);
  localparam logic [CNT_W-1:0] V_REQ_HI = CNT_W'(V_SYNC + V_BACK + V_DISP);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             en_q;
  logic             req_c;
  logic             frame_origin;

  assign frame_origin = (h_cnt == '0) && (v_cnt == '0);

  assign req_c = en_q &&
                 (v_cnt >= V_REQ_LO) && (v_cnt < V_REQ_HI) &&
                 (h_cnt >= H_REQ_LO) && (h_cnt < H_REQ_HI);

  always_comb begin
    data_req   = req_c;
    pixel_xpos = '0;
    pixel_ypos = '0;
    if (req_c) begin
      pixel_xpos = h_cnt - H_REQ_LO;
      pixel_ypos = v_cnt - V_REQ_LO;
    end
  end

  always_ff @(posedge lcd_pclk) begin
    if (!sys_rst_n) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      en_q        <= 1'b0;
      lcd_de      <= 1'b0;
      lcd_hs      <= ~SYNC_ACT;
      lcd_vs      <= ~SYNC_ACT;
      frame_start <= 1'b0;
    end else begin
      if (h_cnt == H_MAX) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_MAX) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end

      // Enable only changes at the frame boundary so a frame is never torn.
      if (frame_origin) begin
        en_q <= disp_en;
      end

      lcd_de      <= req_c;
      lcd_hs      <= (h_cnt < H_SYNC_W) ? SYNC_ACT : ~SYNC_ACT;
      lcd_vs      <= (v_cnt < V_SYNC_W) ? SYNC_ACT : ~SYNC_ACT;
      frame_start <= frame_origin;
    end
  end

  assign lcd_rgb = lcd_de ? pixel_data : '0;

endmodule
